// File: rtl/subtractor_pkg.sv
// Shared state type and default width for the bit-serial subtractor.
package subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sub_state_t;

   localparam int SUB_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle of serial_subtractor; the ovf signal exists only
// when SERIAL_SUBTRACTOR_OVF_EN is defined.
interface serial_subtractor_if #(
   parameter int WIDTH = subtractor_pkg::SUB_DEFAULT_WIDTH
);
   // Handshake: start is accepted on an edge where the block is not busy (IDLE
   // or DONE) and a/b are captured on that edge. busy is high while bits are
   // processed. done pulses for one cycle when diff/borrow become valid. The
   // results then hold until the next result is published.
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             busy;
   logic             done;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic             ovf;

   modport master (output start, a, b, input diff, borrow, busy, done, ovf);
   modport slave  (input start, a, b, output diff, borrow, busy, done, ovf);
`else
   modport master (output start, a, b, input diff, borrow, busy, done);
   modport slave  (input start, a, b, output diff, borrow, busy, done);
`endif

endinterface

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = x - y - bin, bout = borrow out.
module full_subtractor_cell (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single cell.
// Optional signed-overflow output is enabled by SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor
   import subtractor_pkg::*;
#(
   parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   serial_subtractor_if.slave bus,
   output sub_state_t         dbg_state
);

   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   sub_state_t       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             borrow_q, borrow_d;
   logic             cell_d, cell_bout;
   logic             accept, last_bit;
   logic [WIDTH-1:0] res_shifted;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             ovf_q, ovf_d;
`endif

   full_subtractor_cell u_cell (
      .x   (a_sh_q[0]),
      .y   (b_sh_q[0]),
      .bin (br_q),
      .d   (cell_d),
      .bout(cell_bout)
   );

   assign accept      = bus.start && ((state_q == IDLE) || (state_q == DONE));
   assign last_bit    = (state_q == SHIFT) && (cnt_q == LAST_BIT);
   assign res_shifted = {cell_d, res_q[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         br_q     <= 1'b0;
         borrow_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         br_q     <= br_d;
         borrow_q <= borrow_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         ovf_q    <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = SHIFT;
         SHIFT:   if (cnt_q == LAST_BIT) state_d = DONE;
         DONE:    state_d = bus.start ? SHIFT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Visible results change only on the edge that leaves the last SHIFT cycle.
   always_comb begin
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_d    = res_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      br_d     = br_q;
      borrow_d = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      ovf_d    = ovf_q;
`endif
      if (accept) begin
         a_sh_d  = bus.a;
         b_sh_d  = bus.b;
         res_d   = '0;
         cnt_d   = '0;
         br_d    = 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         a_msb_d = bus.a[WIDTH-1];
         b_msb_d = bus.b[WIDTH-1];
`endif
      end else if (state_q == SHIFT) begin
         a_sh_d = a_sh_q >> 1;
         b_sh_d = b_sh_q >> 1;
         res_d  = res_shifted;
         cnt_d  = cnt_q + CNT_W'(1);
         br_d   = cell_bout;
         if (last_bit) begin
            diff_d   = res_shifted;
            borrow_d = cell_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_d    = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
         end
      end
   end

   assign bus.busy   = (state_q == SHIFT);
   assign bus.done   = (state_q == DONE);
   assign bus.diff   = diff_q;
   assign bus.borrow = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   assign bus.ovf    = ovf_q;
`endif
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 4): directed cases,
// back-to-back, reset corners, exhaustive sweep and random ops vs a model.
module tb_serial_subtractor;
   import subtractor_pkg::*;

   localparam int W = 4;

   logic       clk = 1'b0;
   logic       rst;
   sub_state_t dbg_state;
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [W:0] exp_q[$];

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [W:0] ref_sub(input logic [W-1:0] av, input logic [W-1:0] bv);
      int         ai, bi;
      logic [W:0] r;
      ai = int'(av);
      bi = int'(bv);
      r[W]     = (ai < bi);
      r[W-1:0] = W'((ai - bi + (1 << W)) % (1 << W));
      return r;
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] av, input logic [W-1:0] bv);
      int sa, sb, d;
      sa = int'(av);
      sb = int'(bv);
      if (sa >= (1 << (W - 1))) sa -= (1 << W);
      if (sb >= (1 << (W - 1))) sb -= (1 << W);
      d = sa - sb;
      return (d > (1 << (W - 1)) - 1) || (d < -(1 << (W - 1)));
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v);
      int         lat;
      int         busy_n;
      logic [W:0] exp_v;
      logic [W-1:0] held;
      lat    = 0;
      busy_n = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = a_v;
      bus.b     = b_v;
      exp_q.push_back(ref_sub(a_v, b_v));
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = W'($urandom_range(0, (1 << W) - 1));
      bus.b     = W'($urandom_range(0, (1 << W) - 1));
      while (bus.done !== 1'b1 && lat < 20) begin
         if (bus.busy === 1'b1) busy_n++;
         @(posedge clk);
         #1;
         lat++;
      end
      exp_v = exp_q.pop_front();
      check("latency", lat, W);
      check("busy_cycles", busy_n, W);
      check("busy_at_done", bus.busy, 1'b0);
      check("diff", bus.diff, exp_v[W-1:0]);
      check("borrow", bus.borrow, exp_v[W]);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      check("ovf", bus.ovf, ref_ovf(a_v, b_v));
`endif
      held = bus.diff;
      @(posedge clk);
      #1;
      check("done_pulse", bus.done, 1'b0);
      check("diff_hold", bus.diff, exp_v[W-1:0]);
      check("idle_after", dbg_state, IDLE);
   endtask

   task automatic back_to_back();
      logic [W:0] r1, r2;
      r1 = ref_sub(4'd5, 4'd2);
      r2 = ref_sub(4'd1, 4'd4);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 4'd5;
      bus.b     = 4'd2;
      @(posedge clk);
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         bus.a = W'($urandom_range(0, (1 << W) - 1));
         bus.b = W'($urandom_range(0, (1 << W) - 1));
         @(posedge clk);
      end
      #1;
      check("b2b_done1", bus.done, 1'b1);
      check("b2b_diff1", bus.diff, r1[W-1:0]);
      check("b2b_borrow1", bus.borrow, r1[W]);
      @(negedge clk);
      bus.a = 4'd1;
      bus.b = 4'd4;
      @(posedge clk);
      #1;
      check("b2b_reaccept", bus.busy, 1'b1);
      for (int i = 0; i < W - 1; i++) begin
         @(negedge clk);
         bus.a = W'($urandom_range(0, (1 << W) - 1));
         bus.b = W'($urandom_range(0, (1 << W) - 1));
         @(posedge clk);
         #1;
         check("b2b_hold", bus.diff, r1[W-1:0]);
      end
      @(posedge clk);
      #1;
      check("b2b_done2", bus.done, 1'b1);
      check("b2b_diff2", bus.diff, r2[W-1:0]);
      check("b2b_borrow2", bus.borrow, r2[W]);
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      check("b2b_idle", dbg_state, IDLE);
   endtask

   task automatic reset_mid_op();
      logic saw_done;
      saw_done = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 4'd10;
      bus.b     = 4'd3;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_state", dbg_state, IDLE);
      check("rst_diff", bus.diff, 0);
      check("rst_borrow", bus.borrow, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      check("rst_ovf", bus.ovf, 1'b0);
`endif
      @(negedge clk);
      rst = 1'b0;
      repeat (2 * W) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) saw_done = 1'b1;
      end
      check("rst_no_done", saw_done, 1'b0);
   endtask

   task automatic rst_with_start();
      @(negedge clk);
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.a     = 4'd5;
      bus.b     = 4'd3;
      @(posedge clk);
      #1;
      check("rst_start_state", dbg_state, IDLE);
      check("rst_start_busy", bus.busy, 1'b0);
      @(negedge clk);
      rst       = 1'b0;
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      check("rst_start_state2", dbg_state, IDLE);
      check("rst_start_busy2", bus.busy, 1'b0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [W-1:0] dir_a[7];
      logic [W-1:0] dir_b[7];
      dir_a = '{4'd9, 4'd3, 4'd0, 4'd15, 4'd8, 4'd7,  4'd6};
      dir_b = '{4'd3, 4'd9, 4'd1, 4'd15, 4'd1, 4'd15, 4'd2};

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", dbg_state, IDLE);
      check("reset_diff", bus.diff, 0);
      check("reset_borrow", bus.borrow, 1'b0);
      check("reset_busy", bus.busy, 1'b0);
      check("reset_done", bus.done, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      check("reset_ovf", bus.ovf, 1'b0);
`endif
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) run_op(dir_a[i], dir_b[i]);

      back_to_back();
      reset_mid_op();
      run_op(4'd7, 4'd7);
      rst_with_start();

      for (int i = 0; i < (1 << W); i++)
         for (int j = 0; j < (1 << W); j++)
            run_op(W'(i), W'(j));

      do_reset();
      for (int i = 0; i < 30; i++)
         run_op(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
